mod_n_updown_counter: RTL
=========================

MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter register width in bits.
REQ-002 SHALL provide parameter MODULUS, default 14, count sequence length (states 0..MODULUS-1).
REQ-003 SHALL provide parameter RST_VAL, default 0, value loaded into count on reset.
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port en  input  1  count enable; step by one per enabled cycle.
REQ-007 SHALL provide port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL provide port load  input  1  synchronous parallel load request.
REQ-009 SHALL provide port load_val  input  WIDTH  value to load.
REQ-010 SHALL provide port count  output  WIDTH  current count, registered.
REQ-011 SHALL provide port tc  output  1  combinational terminal-count flag for the current direction.
REQ-012 SHALL provide port carry_out  output  1  combinational cascade enable, tc AND en AND NOT load.
REQ-013 SHALL provide port wrap  output  1  registered one-cycle pulse after a wrap-around.
REQ-014 SHALL provide port load_err  output  1  registered one-cycle pulse after a rejected load.
REQ-015 SHALL provide port wrap_cnt  output  16  saturating wrap tally, present only per REQ-032.

Function
REQ-016 Cycle priority SHALL be: rst, then load, then en; with none asserted, count holds.
REQ-017 Load with load_val < MODULUS SHALL set count = load_val on the next edge, regardless of en and up_dn.
REQ-018 Load with load_val >= MODULUS SHALL leave count unchanged, pulse load_err for one cycle and suppress counting that cycle.
REQ-019 en=1, up_dn=1, count < MODULUS-1 SHALL give count+1 on the next edge.
REQ-020 en=1, up_dn=1, count = MODULUS-1 SHALL give count = 0 and wrap = 1 on the next edge.
REQ-021 en=1, up_dn=0, count > 0 SHALL give count-1 on the next edge.
REQ-022 en=1, up_dn=0, count = 0 SHALL give count = MODULUS-1 and wrap = 1 on the next edge.
REQ-023 tc SHALL be 1 when (up_dn=1 and count=MODULUS-1) or (up_dn=0 and count=0), independent of en.
REQ-024 wrap and load_err SHALL be low in every cycle not covered by REQ-018, REQ-020 and REQ-022; they are never both high.
REQ-025 Direction change SHALL take effect on the same edge; no extra latency or skipped state.
REQ-026 MODULUS < 2, MODULUS > 2**WIDTH or RST_VAL >= MODULUS SHALL cause an elaboration-time error.
REQ-027 Arithmetic SHALL be performed in WIDTH bits; count SHALL never hold a value >= MODULUS.

Reset
REQ-028 rst=1 at a rising edge SHALL set count = RST_VAL, wrap = 0, load_err = 0, wrap_cnt = 0, overriding load and en.
REQ-029 Reset asserted mid-sequence SHALL discard any pending wrap or load outcome with no residual pulse after release.
REQ-030 First enabled edge after rst deasserts SHALL step from RST_VAL per REQ-019..REQ-022.

Configuration
REQ-031 Macro MOD_N_UPDOWN_COUNTER_WRAPCNT_EN SHALL control the wrap tally feature.
REQ-032 With the macro defined, wrap_cnt SHALL exist and increment by one at every wrap pulse, saturating at 16'hFFFF; without it, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 WIDTH=4, MODULUS=14: rst then en=1, up_dn=1 for 15 cycles -> count 0,1,..,13,0; wrap high only in the cycle count=0 after 13.
REQ-034 Count=0, en=1, up_dn=0 -> count=13, wrap=1; next cycle 12, wrap=0; tc=1 while count=0.
REQ-035 load=1, load_val=9, en=1 -> count=9, no step that cycle; load_val=14 -> count held, load_err=1 for one cycle.
REQ-036 Count=13, en=1, rst=1 and load=1 together -> count=RST_VAL, wrap=0, load_err=0.
REQ-037 Two instances cascaded (upper en = lower carry_out), MODULUS=14 each -> upper steps once per 14 lower steps; 196 cycles return both to 0.
REQ-038 With MOD_N_UPDOWN_COUNTER_WRAPCNT_EN, 3 full up wraps -> wrap_cnt=3; forced to 16'hFFFF, one more wrap -> stays 16'hFFFF.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with synchronous load, terminal-count cascade output and wrap/load-error pulses.
// Optional 16-bit saturating wrap tally enabled by defining MOD_N_UPDOWN_COUNTER_WRAPCNT_EN.
module mod_n_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 14,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry_out,
  output logic             wrap,
  output logic             load_err
`ifdef MOD_N_UPDOWN_COUNTER_WRAPCNT_EN
  ,
  output logic [15:0]      wrap_cnt
`endif
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_cfg
    $error("mod_n_updown_counter: illegal WIDTH/MODULUS/RST_VAL combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RST_VAL);
  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;
  logic             load_ok;

  always_comb begin
    tc        = up_dn ? (count == MAX_VAL) : (count == '0);
    carry_out = tc & en & ~load;
    load_ok   = ({1'b0, load_val} < MOD_EXT);
  end

  // Next-state: load outranks counting; a rejected load still blocks the step.
  always_comb begin
    count_nxt    = count;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_nxt = load_val;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (count == MAX_VAL) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = MAX_VAL;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= INIT_VAL;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
    end
  end

`ifdef MOD_N_UPDOWN_COUNTER_WRAPCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt <= 16'd0;
    end else if (wrap_nxt) begin
      wrap_cnt <= sat_inc16(wrap_cnt);
    end
  end
`endif

endmodule
